// File: rtl/alu_issue_seq_if.sv
// Interface bundle for alu_issue_seq: instruction byte stream, alu drive/result
// lines and the req/ack memory port. The sequencer uses modport master; the
// environment (alu, memory, instruction source) uses modport slave.
interface alu_issue_seq_if;
   // Instruction byte stream
   logic       instrValid;
   logic [7:0] instrData;
   logic       instrReady;
   // Combinational alu
   logic [1:0] aluOpcode;
   logic [3:0] aluAddrs;
   logic [7:0] aluDIn0;
   logic [7:0] aluDIn1;
   logic [7:0] aluDOut;
   logic       aluCarry;
   logic       aluBorrow;
   logic       aluCarryEnable;
   logic       aluBcf;
   logic       aluMemWrite;
   logic       aluMemRead;
   logic       aluToggleOut;
   // Memory port
   logic       memReq;
   logic       memWe;
   logic [3:0] memAddr;
   logic [7:0] memWData;
   logic [7:0] memRData;
   logic       memAck;

   modport master (
      input  instrValid, instrData,
      output instrReady,
      output aluOpcode, aluAddrs, aluDIn0, aluDIn1,
      input  aluDOut, aluCarry, aluBorrow, aluCarryEnable, aluBcf,
      input  aluMemWrite, aluMemRead, aluToggleOut,
      output memReq, memWe, memAddr, memWData,
      input  memRData, memAck
   );

   modport slave (
      output instrValid, instrData,
      input  instrReady,
      input  aluOpcode, aluAddrs, aluDIn0, aluDIn1,
      output aluDOut, aluCarry, aluBorrow, aluCarryEnable, aluBcf,
      output aluMemWrite, aluMemRead, aluToggleOut,
      input  memReq, memWe, memAddr, memWData,
      output memRData, memAck
   );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: fetches 2-byte instructions, drives the combinational alu in a
// single EXEC cycle, writes results back into a 4-entry register file, services
// alu memory requests with a timeout, and implements bcf skip of the next
// instruction. Optional retire counter enabled by defining ALU_SEQ_PERF_EN.
module alu_issue_seq #(
   parameter int unsigned MEM_TIMEOUT = 15
`ifdef ALU_SEQ_PERF_EN
   ,
   parameter int unsigned CNT_W = 8
`endif
) (
   input  logic clk,
   input  logic rst_n,
   alu_issue_seq_if.master bus,
   output logic toggleQ,
   output logic carryFlag,
   output logic errSticky,
   output logic busy
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [CNT_W-1:0] retireCnt
`endif
);

   localparam int unsigned NREGS = 4;
   localparam logic [7:0] TimeoutLast = 8'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {StFetch0, StFetch1, StExec, StMem} state_e;

   state_e     stateQ, stateD;
   logic [1:0] opcodeQ, opcodeD;
   logic [3:0] addrsQ, addrsD;
   logic [1:0] rselQ, rselD;
   logic [7:0] immQ, immD;
   logic [7:0] regQ [NREGS];
   logic       carryQ, carryD;
   logic       toggleD;
   logic       skipQ, skipD;
   logic       errQ, errD;
   logic       memWeQ, memWeD;
   logic [7:0] waitQ, waitD;
   logic       regWe;
   logic [7:0] regWData;
   logic       memAccess;
   logic       aluActive;

   assign memAccess = bus.aluMemWrite | bus.aluMemRead;
   assign aluActive = (stateQ == StExec) || (stateQ == StMem);

   // State, instruction fields, flags and register file
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateQ  <= StFetch0;
         opcodeQ <= '0;
         addrsQ  <= '0;
         rselQ   <= '0;
         immQ    <= '0;
         carryQ  <= 1'b0;
         toggleQ <= 1'b0;
         skipQ   <= 1'b0;
         errQ    <= 1'b0;
         memWeQ  <= 1'b0;
         waitQ   <= '0;
         for (int i = 0; i < NREGS; i++) regQ[i] <= '0;
      end else begin
         stateQ  <= stateD;
         opcodeQ <= opcodeD;
         addrsQ  <= addrsD;
         rselQ   <= rselD;
         immQ    <= immD;
         carryQ  <= carryD;
         toggleQ <= toggleD;
         skipQ   <= skipD;
         errQ    <= errD;
         memWeQ  <= memWeD;
         waitQ   <= waitD;
         if (regWe) regQ[rselQ] <= regWData;
      end
   end

   // Next-state, writeback select and handshake
   always_comb begin
      stateD     = stateQ;
      opcodeD    = opcodeQ;
      addrsD     = addrsQ;
      rselD      = rselQ;
      immD       = immQ;
      carryD     = carryQ;
      toggleD    = toggleQ;
      skipD      = skipQ;
      errD       = errQ;
      memWeD     = memWeQ;
      waitD      = waitQ;
      regWe      = 1'b0;
      regWData   = bus.aluDOut;
      bus.instrReady = 1'b0;
      case (stateQ)
         StFetch0: begin
            bus.instrReady = 1'b1;
            if (bus.instrValid) begin
               opcodeD = bus.instrData[7:6];
               addrsD  = bus.instrData[5:2];
               rselD   = bus.instrData[1:0];
               stateD  = StFetch1;
            end
         end
         StFetch1: begin
            bus.instrReady = 1'b1;
            if (bus.instrValid) begin
               immD = bus.instrData;
               // A pending skip swallows this instruction without touching the alu
               if (skipQ) begin
                  skipD  = 1'b0;
                  stateD = StFetch0;
               end else begin
                  stateD = StExec;
               end
            end
         end
         StExec: begin
            stateD = StFetch0;
            waitD  = '0;
            if (memAccess) begin
               stateD = StMem;
               memWeD = bus.aluMemWrite;
            end else if (bus.aluCarryEnable) begin
               carryD = (opcodeQ == 2'b00) ? bus.aluCarry : bus.aluBorrow;
            end
            if (bus.aluToggleOut) toggleD = ~toggleQ;
            // Skip decision uses the flag as it was before this instruction
            if (bus.aluBcf) skipD = carryQ;
            if (!(memAccess || bus.aluBcf || bus.aluToggleOut)) regWe = 1'b1;
         end
         StMem: begin
            // Ack takes priority over a timeout landing in the same cycle
            if (bus.memAck) begin
               if (!memWeQ) begin
                  regWe    = 1'b1;
                  regWData = bus.memRData;
               end
               stateD = StFetch0;
            end else if (waitQ == TimeoutLast) begin
               errD   = 1'b1;
               stateD = StFetch0;
            end else begin
               waitD = waitQ + 8'd1;
            end
         end
         default: stateD = StFetch0;
      endcase
   end

   // Alu and memory drive: operands only while an instruction is in flight
   always_comb begin
      bus.aluOpcode = opcodeQ;
      bus.aluAddrs  = addrsQ;
      bus.aluDIn0   = aluActive ? regQ[rselQ] : 8'h00;
      bus.aluDIn1   = aluActive ? immQ : 8'h00;
      bus.memReq    = (stateQ == StMem);
      bus.memWe     = memWeQ;
      bus.memAddr   = addrsQ;
      bus.memWData  = regQ[rselQ];
   end

   assign carryFlag = carryQ;
   assign errSticky = errQ;
   assign busy      = (stateQ != StFetch0);

`ifdef ALU_SEQ_PERF_EN
   logic [CNT_W-1:0] cntQ;

   // Retired-instruction counter; skipped instructions never reach EXEC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cntQ <= '0;
      else if (stateQ == StExec) cntQ <= cntQ + 1'b1;
   end

   assign retireCnt = cntQ;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed self-checking bench for alu_issue_seq. The bench plays the alu, the
// memory and the instruction source. Bench alu decode:
//   op 00 add (carry enable), op 01 sub (carry enable), op 10 memWrite,
//   op 11 by immediate: 00 bcf, 01 memRead, 02 toggle, other = pass dIn0 (peek).
module tb_alu_issue_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic toggleQ, carryFlag, errSticky, busy;
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   logic [8:0] sum9;

   alu_issue_seq_if bus ();

`ifdef ALU_SEQ_PERF_EN
   logic [7:0] retireCnt;
`endif

   alu_issue_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .toggleQ   (toggleQ),
      .carryFlag (carryFlag),
      .errSticky (errSticky),
      .busy      (busy)
`ifdef ALU_SEQ_PERF_EN
      ,
      .retireCnt (retireCnt)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Bench alu model
   always_comb begin
      sum9               = {1'b0, bus.aluDIn0} + {1'b0, bus.aluDIn1};
      bus.aluDOut        = 8'hEE;
      bus.aluCarry       = sum9[8];
      bus.aluBorrow      = (bus.aluDIn0 < bus.aluDIn1);
      bus.aluCarryEnable = 1'b0;
      bus.aluBcf         = 1'b0;
      bus.aluMemWrite    = 1'b0;
      bus.aluMemRead     = 1'b0;
      bus.aluToggleOut   = 1'b0;
      case (bus.aluOpcode)
         2'b00: begin bus.aluDOut = sum9[7:0]; bus.aluCarryEnable = 1'b1; end
         2'b01: begin bus.aluDOut = bus.aluDIn0 - bus.aluDIn1; bus.aluCarryEnable = 1'b1; end
         2'b10: bus.aluMemWrite = 1'b1;
         default: begin
            case (bus.aluDIn1)
               8'h00:   bus.aluBcf = 1'b1;
               8'h01:   bus.aluMemRead = 1'b1;
               8'h02:   bus.aluToggleOut = 1'b1;
               default: bus.aluDOut = bus.aluDIn0;
            endcase
         end
      endcase
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents both bytes; returns in the cycle after byte1 is taken (EXEC unless skipped)
   task automatic sendInstr(input logic [7:0] b0, input logic [7:0] b1);
      int n = 0;
      while (!bus.instrReady && n < 40) begin
         step();
         n++;
      end
      total++;
      if (n == 40) begin
         $display("FAIL sendInstr_wait: instrReady still %b after %0d cycles, need 1", bus.instrReady, n);
         bad++;
      end
      bus.instrValid = 1'b1;
      bus.instrData  = b0;
      step();
      bus.instrData  = b1;
      step();
      bus.instrValid = 1'b0;
      bus.instrData  = 8'h00;
   endtask

   // Reads reg r through a pass-through instruction that writes the same value back
   task automatic peek(input logic [1:0] r, output logic [7:0] v);
      sendInstr({2'b11, 4'b0000, r}, 8'h03);
      v = bus.aluDIn0;
      step();
   endtask

   task automatic test_reset();
      #3;
      total++; if (bus.memReq !== 1'b0) begin $display("FAIL reset_memReq: got %b need 0", bus.memReq); bad++; end
      total++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b need 0", busy); bad++; end
      total++; if (bus.instrReady !== 1'b1) begin $display("FAIL reset_ready: got %b need 1", bus.instrReady); bad++; end
      total++; if ({carryFlag, toggleQ, errSticky} !== 3'b000) begin
         $display("FAIL reset_flags: got %b need 000", {carryFlag, toggleQ, errSticky}); bad++; end
      total++; if ({bus.aluDIn0, bus.aluDIn1} !== 16'h0000) begin
         $display("FAIL reset_operands: got %h need 0000", {bus.aluDIn0, bus.aluDIn1}); bad++; end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      logic [7:0] v;
      sendInstr(8'b00_0000_01, 8'h05);
      total++; if (bus.instrReady !== 1'b0) begin $display("FAIL add_exec_ready: got %b need 0", bus.instrReady); bad++; end
      total++; if (busy !== 1'b1) begin $display("FAIL add_exec_busy: got %b need 1", busy); bad++; end
      total++; if ({bus.aluDIn0, bus.aluDIn1} !== 16'h0005) begin
         $display("FAIL add_operands: got %h need 0005", {bus.aluDIn0, bus.aluDIn1}); bad++; end
      step();
      total++; if (carryFlag !== 1'b0) begin $display("FAIL add_carry0: got %b need 0", carryFlag); bad++; end
      sendInstr(8'b00_0000_01, 8'hFF);
      total++; if (bus.aluDIn0 !== 8'h05) begin $display("FAIL add_reg1_05: got %h need 05", bus.aluDIn0); bad++; end
      step();
      total++; if (carryFlag !== 1'b1) begin $display("FAIL add_carry1: got %b need 1", carryFlag); bad++; end
      peek(2'd1, v);
      total++; if (v !== 8'h04) begin $display("FAIL add_wrap_reg1: got %h need 04", v); bad++; end
   endtask

   task automatic test_sub();
      logic [7:0] v;
      sendInstr(8'b01_0000_10, 8'h01);
      total++; if (bus.instrReady !== 1'b0) begin $display("FAIL sub_exec_ready: got %b need 0", bus.instrReady); bad++; end
      total++; if (bus.aluDIn0 !== 8'h00) begin $display("FAIL sub_reg2_in: got %h need 00", bus.aluDIn0); bad++; end
      step();
      total++; if (bus.instrReady !== 1'b1) begin $display("FAIL sub_fetch_ready: got %b need 1", bus.instrReady); bad++; end
      total++; if (carryFlag !== 1'b1) begin $display("FAIL sub_borrow: got %b need 1", carryFlag); bad++; end
      peek(2'd2, v);
      total++; if (v !== 8'hFF) begin $display("FAIL sub_reg2: got %h need ff", v); bad++; end
   endtask

   task automatic test_back_to_back();
      int t [3];
      logic [7:0] v;
      for (int k = 0; k < 3; k++) begin
         sendInstr(8'b11_0000_00, 8'h02);
         t[k] = cyc;
         step();
      end
      total++; if ((t[1] - t[0]) !== 3 || (t[2] - t[1]) !== 3) begin
         $display("FAIL b2b_spacing: got %0d,%0d cycles need 3,3", t[1] - t[0], t[2] - t[1]); bad++; end
      total++; if (toggleQ !== 1'b1) begin $display("FAIL b2b_toggle: got %b need 1", toggleQ); bad++; end
      peek(2'd0, v);
      total++; if (v !== 8'h00) begin $display("FAIL toggle_no_wb: got %h need 00", v); bad++; end
   endtask

   task automatic test_mem_write();
      int ok = 0;
      sendInstr(8'b00_0000_11, 8'h5A);
      step();
      sendInstr(8'b10_1010_11, 8'h00);
      total++; if (bus.memReq !== 1'b0) begin $display("FAIL memw_exec_req: got %b need 0", bus.memReq); bad++; end
      step();
      for (int i = 0; i < 3; i++) begin
         if (bus.memReq === 1'b1 && bus.memWe === 1'b1 && bus.memAddr === 4'b1010 &&
             bus.memWData === 8'h5A && busy === 1'b1 && bus.instrReady === 1'b0) ok++;
         if (i == 2) bus.memAck = 1'b1;
         step();
         bus.memAck = 1'b0;
      end
      total++; if (ok !== 3) begin $display("FAIL memw_fields: got %0d good cycles need 3", ok); bad++; end
      total++; if ({bus.memReq, busy} !== 2'b00) begin
         $display("FAIL memw_release: got req/busy %b need 00", {bus.memReq, busy}); bad++; end
      total++; if (errSticky !== 1'b0) begin $display("FAIL memw_err: got %b need 0", errSticky); bad++; end
   endtask

   task automatic test_bcf();
      logic [7:0] v;
      // carry=1: add to r0 is skipped
      sendInstr(8'b00_0000_11, 8'hFF);
      step();
      total++; if (carryFlag !== 1'b1) begin $display("FAIL bcf_setup_c1: got %b need 1", carryFlag); bad++; end
      sendInstr(8'b11_0000_00, 8'h00);
      step();
      sendInstr(8'b00_0000_00, 8'h10);
      total++; if (busy !== 1'b0) begin $display("FAIL bcf_skip_noexec: busy %b need 0", busy); bad++; end
      peek(2'd0, v);
      total++; if (v !== 8'h00) begin $display("FAIL bcf_skip_r0: got %h need 00", v); bad++; end
      // carry=0: add to r0 executes
      sendInstr(8'b00_0000_10, 8'h00);
      step();
      total++; if (carryFlag !== 1'b0) begin $display("FAIL bcf_setup_c0: got %b need 0", carryFlag); bad++; end
      sendInstr(8'b11_0000_00, 8'h00);
      step();
      sendInstr(8'b00_0000_00, 8'h10);
      step();
      peek(2'd0, v);
      total++; if (v !== 8'h10) begin $display("FAIL bcf_noskip_r0: got %h need 10", v); bad++; end
      // skipped bcf does not chain a second skip
      sendInstr(8'b00_0000_11, 8'hFF);
      step();
      sendInstr(8'b11_0000_00, 8'h00);
      step();
      sendInstr(8'b11_0000_00, 8'h00);
      sendInstr(8'b00_0000_00, 8'h01);
      step();
      peek(2'd0, v);
      total++; if (v !== 8'h11) begin $display("FAIL bcf_nochain_r0: got %h need 11", v); bad++; end
   endtask

   task automatic test_ack_at_timeout();
      int hi = 0;
      logic [7:0] v;
      bus.memRData = 8'h3C;
      sendInstr(8'b11_0110_00, 8'h01);
      step();
      for (int i = 0; i < 15; i++) begin
         if (bus.memReq === 1'b1) hi++;
         if (i == 14) bus.memAck = 1'b1;
         step();
         bus.memAck = 1'b0;
      end
      total++; if (hi !== 15) begin $display("FAIL ackto_req_cycles: got %0d need 15", hi); bad++; end
      total++; if (errSticky !== 1'b0) begin $display("FAIL ackto_err: got %b need 0", errSticky); bad++; end
      peek(2'd0, v);
      total++; if (v !== 8'h3C) begin $display("FAIL ackto_read_r0: got %h need 3c", v); bad++; end
   endtask

   task automatic test_mem_timeout();
      int cnt = 0;
      logic [7:0] v;
      bus.memRData = 8'h99;
      sendInstr(8'b11_0001_01, 8'h01);
      step();
      while (bus.memReq === 1'b1 && cnt < 40) begin
         cnt++;
         step();
      end
      total++; if (cnt !== 15) begin $display("FAIL to_req_cycles: got %0d need 15", cnt); bad++; end
      total++; if (errSticky !== 1'b1) begin $display("FAIL to_err: got %b need 1", errSticky); bad++; end
      total++; if (busy !== 1'b0) begin $display("FAIL to_busy: got %b need 0", busy); bad++; end
      peek(2'd1, v);
      total++; if (v !== 8'h04) begin $display("FAIL to_r1_kept: got %h need 04", v); bad++; end
      // stray ack while idle must do nothing
      bus.memRData = 8'h77;
      bus.memAck   = 1'b1;
      step();
      bus.memAck   = 1'b0;
      total++; if (busy !== 1'b0) begin $display("FAIL stray_ack_busy: got %b need 0", busy); bad++; end
      peek(2'd1, v);
      total++; if (v !== 8'h04) begin $display("FAIL stray_ack_r1: got %h need 04", v); bad++; end
   endtask

   task automatic test_async_reset();
      logic [7:0] v;
      sendInstr(8'b10_0011_11, 8'h00);
      step();
      total++; if (bus.memReq !== 1'b1) begin $display("FAIL ar_pre_req: got %b need 1", bus.memReq); bad++; end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({bus.memReq, busy} !== 2'b00) begin
         $display("FAIL ar_req_busy: got %b need 00", {bus.memReq, busy}); bad++; end
      total++; if ({carryFlag, toggleQ, errSticky} !== 3'b000) begin
         $display("FAIL ar_flags: got %b need 000", {carryFlag, toggleQ, errSticky}); bad++; end
      #2;
      rst_n = 1'b1;
      step();
      total++; if (bus.instrReady !== 1'b1) begin $display("FAIL ar_fetch0: got %b need 1", bus.instrReady); bad++; end
      peek(2'd3, v);
      total++; if (v !== 8'h00) begin $display("FAIL ar_r3: got %h need 00", v); bad++; end
      peek(2'd1, v);
      total++; if (v !== 8'h00) begin $display("FAIL ar_r1: got %h need 00", v); bad++; end
   endtask

   initial begin
      bus.instrValid = 1'b0;
      bus.instrData  = 8'h00;
      bus.memAck     = 1'b0;
      bus.memRData   = 8'h00;
      test_reset();
      test_add();
      test_sub();
      test_back_to_back();
      test_mem_write();
      test_bcf();
      test_ack_at_timeout();
      test_mem_timeout();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
